run_controller: RTL

- Run/step/halt sequencer for the 5-stage pipeline.
- Produces the single `go` freeze/advance enable that gates PC and all inter-stage buffers.
- Arbitrates between board buttons (run, single-step), the WB-stage syscall halt, a PC breakpoint comparator and a cycle budget.
- Sits between the button/debug inputs and the datapath's `go` net; also exports state, halt cause and an executed-cycle counter for the display mux.

---
 rtl/run_controller.sv | 139 +++++++++++++
 1 files changed

// File: rtl/run_controller.sv
// Run/step/halt sequencer producing the pipeline-wide go enable, with halt cause
// tracking and a saturating count of executed (go=1) cycles.
module run_controller #(
  parameter int PC_W  = 12,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_btn,
  input  logic             step_btn,
  input  logic             halt_req,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  input  logic [CNT_W-1:0] budget,
  output logic             go,
  output logic [1:0]       state,
  output logic [1:0]       cause,
  output logic [CNT_W-1:0] run_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    HALT = 2'b11
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_SYS  = 2'b01;
  localparam logic [1:0] CAUSE_BP   = 2'b10;
  localparam logic [1:0] CAUSE_BUD  = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       cause_q, cause_d;
  logic             run_q, step_q;
  logic             bp_arm, bp_arm_d;
  logic [CNT_W-1:0] cnt_q;
  logic             run_e, step_e, bp_hit, last;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Widened by one bit so an all-ones count cannot wrap past the budget.
  function automatic logic budget_last(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] bud);
    logic [CNT_W:0] nxt;
    nxt = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    return (bud != '0) && (nxt >= {1'b0, bud});
  endfunction

  assign run_e      = run_btn & ~run_q;
  assign step_e     = step_btn & ~step_q;
  assign last       = budget_last(cnt_q, budget);
  assign bp_hit     = bp_en & bp_arm & (pc == bp_addr);

  assign go         = (state_q == RUN) || (state_q == STEP);
  assign state      = state_q;
  assign cause      = cause_q;
  assign run_cycles = cnt_q;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      IDLE: begin
        if (run_e)       state_d = RUN;
        else if (step_e) state_d = STEP;
      end
      RUN: begin
        if (halt_req) begin
          state_d = HALT;
          cause_d = CAUSE_SYS;
        end else if (bp_hit) begin
          state_d = HALT;
          cause_d = CAUSE_BP;
        end else if (last) begin
          state_d = HALT;
          cause_d = CAUSE_BUD;
        end else if (run_e) begin
          state_d = IDLE;
          cause_d = CAUSE_NONE;
        end
      end
      STEP: begin
        if (halt_req) begin
          state_d = HALT;
          cause_d = CAUSE_SYS;
        end else if (last) begin
          state_d = HALT;
          cause_d = CAUSE_BUD;
        end else begin
          state_d = IDLE;
          cause_d = CAUSE_NONE;
        end
      end
      HALT: begin
        // A syscall halt is terminal until reset.
        if (cause_q != CAUSE_SYS) begin
          if (run_e) begin
            state_d = RUN;
            cause_d = CAUSE_NONE;
          end else if (step_e) begin
            state_d = STEP;
            cause_d = CAUSE_NONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cause_d = CAUSE_NONE;
      end
    endcase
  end

  // Arm only once a RUN has survived its first go cycle, so a resume at the
  // breakpoint PC does not re-trip immediately.
  assign bp_arm_d = (state_q == RUN) && (state_d == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cause_q <= CAUSE_NONE;
      run_q   <= 1'b0;
      step_q  <= 1'b0;
      bp_arm  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      run_q   <= run_btn;
      step_q  <= step_btn;
      bp_arm  <= bp_arm_d;
      if (go) cnt_q <= sat_inc(cnt_q);
    end
  end

endmodule
